// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the PC sequencer: state encoding and
// default reset PC / instruction size.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        HALT   = 2'b11
    } state_e;

    localparam int unsigned DEFAULT_ADDR_W      = 32;
    localparam int unsigned DEFAULT_RESET_PC    = 0;
    localparam int unsigned DEFAULT_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer-side bus: fetch handshake, pipeline control inputs and PC/status outputs.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              fetch_ack;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic              ir_load;
    logic              choose;
    logic [1:0]        state_o;
    logic              halted;

    modport master (
        input  fetch_ack, stall, branch_taken, branch_target, halt,
        output pc, fetch_req, ir_load, choose, state_o, halted
    );

    modport slave (
        output fetch_ack, stall, branch_taken, branch_target, halt,
        input  pc, fetch_req, ir_load, choose, state_o, halted
    );
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC: sequential increment or aligned branch redirect.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] next_pc_o
);
    // INSTR_BYTES is a power of two, so INSTR_BYTES-1 covers exactly the offset bits
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES) - ADDR_W'(1));

    always_comb begin
        if (branch_taken_i) begin
            next_pc_o = branch_target_i & ALIGN_MASK;
        end else begin
            next_pc_o = pc_i + ADDR_W'(INSTR_BYTES);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute PC sequencer with halt state.
// Optional stall counter output enabled by PC_SEQUENCER_STALL_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.master    bus
`ifdef PC_SEQUENCER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic              fetch_req_c;
    logic              ir_load_c;
    logic              choose_c;
    logic              halted_c;

    pc_next_calc #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_calc (
        .pc_i            (pc_q),
        .branch_taken_i  (bus.branch_taken),
        .branch_target_i (bus.branch_target),
        .next_pc_o       (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and control outputs decoded from the current state
    always_comb begin
        state_d     = state_q;
        fetch_req_c = 1'b0;
        ir_load_c   = 1'b0;
        choose_c    = 1'b1;
        halted_c    = 1'b0;
        case (state_q)
            FETCH: begin
                fetch_req_c = 1'b1;
                if (bus.fetch_ack) begin
                    ir_load_c = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (!bus.stall) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!bus.stall) begin
                    choose_c = 1'b0;
                    state_d  = bus.halt ? HALT : FETCH;
                end
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // choose=1 recirculates the current PC, choose=0 commits the computed one
    always_comb begin
        pc_d = choose_c ? pc_q : next_pc;
    end

    assign bus.pc        = pc_q;
    assign bus.fetch_req = fetch_req_c;
    assign bus.ir_load   = ir_load_c;
    assign bus.choose    = choose_c;
    assign bus.halted    = halted_c;
    assign bus.state_o   = state_q;

`ifdef PC_SEQUENCER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Saturating count of stalled DECODE/EXEC cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == DECODE) || (state_q == EXEC)) && bus.stall &&
            (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a random phase
// checked against an instruction-level reference model.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam longint      RPC    = 0;
    localparam longint      IB     = 4;
    localparam longint      MOD    = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef PC_SEQUENCER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (32'(RPC)),
        .INSTR_BYTES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PC_SEQUENCER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0=fetch,1=decode,2=exec,3=halt (values of state_o)
    int     m_phase;
    longint m_pc;
    longint m_stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_pc     = RPC;
        m_stalls = 0;
    endtask

    task automatic check_outputs(input string tag, input logic ack, input logic stl);
        chk({tag, ".pc"},        64'(bus.pc),        64'(m_pc));
        chk({tag, ".state"},     64'(bus.state_o),   64'(m_phase));
        chk({tag, ".fetch_req"}, 64'(bus.fetch_req), 64'(m_phase == 0));
        chk({tag, ".ir_load"},   64'(bus.ir_load),   64'(m_phase == 0 && ack));
        chk({tag, ".choose"},    64'(bus.choose),    64'(!(m_phase == 2 && !stl)));
        chk({tag, ".halted"},    64'(bus.halted),    64'(m_phase == 3));
`ifdef PC_SEQUENCER_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt),     64'(m_stalls));
`endif
    endtask

    // One clock: drive inputs, check pre-edge outputs, advance model at the edge
    task automatic step(input string tag, input logic ack, input logic stl,
                        input logic br, input logic [31:0] tgt, input logic hlt);
        bus.fetch_ack     = ack;
        bus.stall         = stl;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.halt          = hlt;
        #1;
        check_outputs(tag, ack, stl);
        @(posedge clk);
        case (m_phase)
            0: if (ack) m_phase = 1;
            1: if (stl) m_stalls++; else m_phase = 2;
            2: begin
                if (stl) m_stalls++;
                else begin
                    if (br) m_pc = (longint'(tgt) / IB) * IB;
                    else    m_pc = (m_pc + IB) % MOD;
                    m_phase = hlt ? 3 : 0;
                end
            end
            default: m_phase = 3;
        endcase
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".pc"},    64'(bus.pc),      64'(RPC));
        chk({tag, ".state"}, 64'(bus.state_o), 64'd0);
`ifdef PC_SEQUENCER_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        bus.fetch_ack = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = '0; bus.halt = 1'b0;

        // Outputs while reset is held
        #1;
        check_outputs("rst_noack", 1'b0, 1'b0);
        bus.fetch_ack = 1'b1;
        #1;
        check_outputs("rst_ack", 1'b1, 1'b0);
        rst = 1'b0;

        // Back-to-back instructions: pc 0,4,8, commit every third cycle
        for (int i = 0; i < 9; i++) step("seq", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq.pc_after3", 64'(bus.pc), 64'hC);

        // Delayed acknowledge: five waiting cycles with pc held
        for (int i = 0; i < 5; i++) step("ackwait", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("ackgo", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("ackdec", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("ackexe", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Branch with misaligned target
        step("br_f", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("br_d", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("br_e", 1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
        chk("br.pc", 64'(bus.pc), 64'h100);

        // Stalled EXEC with branch pending, redirect only on release
        step("bst_f", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("bst_d", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("bst_d2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step("bst_e", 1'b0, 1'b1, 1'b1, 32'h2468, 1'b1);
        chk("bst.pc_held", 64'(bus.pc), 64'h100);
        step("bst_go", 1'b0, 1'b0, 1'b1, 32'h2468, 1'b0);
        chk("bst.pc", 64'(bus.pc), 64'h2468);

        // Wrap at top of address space, then halt
        step("wr_f", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("wr_d", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("wr_e", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        chk("wr.top", 64'(bus.pc), 64'hFFFF_FFFC);
        step("wr_f2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("wr_d2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("wr_e2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wr.zero", 64'(bus.pc), 64'h0);
        step("h_f", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("h_d", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("h_e", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("h.halted", 64'(bus.halted), 64'h1);
        chk("h.pc", 64'(bus.pc), 64'h4);
        for (int i = 0; i < 4; i++)
            step("h_hold", 1'(i), 1'b0, 1'b1, 32'h5550, 1'b1);

        // Asynchronous reset in the middle of DECODE
        pulse_reset("rst_halt");
        step("ad_f", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step("ad_d", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        pulse_reset("rst_dec");
        step("ad_after", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Random traffic against the model; recover from HALT with a reset
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 3 && $urandom_range(0, 3) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, PC and address width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter INSTR_BYTES, default 4, PC increment per instruction (power of two).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fetch_ack  input  1  instruction memory: fetched word valid this cycle.
REQ-007 stall  input  1  freeze DECODE/EXEC in the current state.
REQ-008 branch_taken  input  1  sampled in EXEC; redirect PC.
REQ-009 branch_target  input  ADDR_W  redirect address.
REQ-010 halt  input  1  sampled in EXEC; stop after the current instruction.
REQ-011 pc  output  ADDR_W  current PC register.
REQ-012 fetch_req  output  1  request fetch at pc.
REQ-013 ir_load  output  1  one-cycle strobe: latch fetched instruction.
REQ-014 choose  output  1  PC mux select: 0 = next PC, 1 = same PC.
REQ-015 state_o  output  2  current state encoding.
REQ-016 halted  output  1  sequencer in HALT.

Function
REQ-017 States: FETCH=2'b00, DECODE=2'b01, EXEC=2'b10, HALT=2'b11; single registered state, with next-state and outputs decoded combinationally from it.
REQ-018 FETCH: fetch_req=1; on fetch_ack, ir_load=1 in the same cycle and the next state is DECODE; without ack, remain in FETCH.
REQ-019 fetch_ack outside FETCH is ignored.
REQ-020 DECODE: stall=1 holds DECODE; otherwise the next state is EXEC.
REQ-021 EXEC with stall=1: hold EXEC; branch_taken and halt are ignored that cycle.
REQ-022 EXEC with stall=0: choose=0 and pc updates at the clock edge, then FETCH.
REQ-023 PC update: branch_taken=1 loads branch_target with its low log2(INSTR_BYTES) bits forced to zero; otherwise pc+INSTR_BYTES, modulo 2^ADDR_W (wraps silently).
REQ-024 choose=1 in every cycle except the committing EXEC cycle (REQ-022).
REQ-025 EXEC with stall=0 and halt=1: commit the PC update, then go to HALT instead of FETCH.
REQ-026 HALT: fetch_req=0, choose=1, halted=1, pc frozen; exit only by reset.
REQ-027 halt and branch_taken together: the branch target is committed, then HALT.
REQ-028 Minimum instruction latency: 3 cycles (ack in the first cycle, no stall).

Reset
REQ-029 rst=1 immediately forces state=FETCH and pc=RESET_PC, independent of clk.
REQ-030 Reset values of outputs: fetch_req=1, ir_load=0 unless fetch_ack=1, choose=1, halted=0, state_o=2'b00.
REQ-031 A reset asserted mid-fetch or mid-EXEC aborts the instruction with no PC commit, and the first fetch after release is at RESET_PC.

Configuration
REQ-032 Macro PC_SEQUENCER_STALL_CNT_EN defined: adds output stall_cnt (32 bits), incremented each cycle stall=1 in DECODE/EXEC, saturating at 2^32-1, reset to 0.
REQ-033 Macro undefined: there is no stall_cnt port or counter logic, and all other behaviour is identical.

Structure
REQ-034 Shared package pc_seq_pkg holds the state encodings FETCH/DECODE/EXEC/HALT, the state typedef, and the default RESET_PC and INSTR_BYTES constants.
REQ-035 One sub-module, pc_next_calc: combinational next-PC computation (increment, redirect, alignment mask); the FSM and PC register stay in the top level.

Verification
REQ-036 Reset release with fetch_ack tied high and no stall -> pc sequence 0, 4, 8, and choose=0 every third cycle, exactly in each EXEC cycle.
REQ-037 fetch_ack delayed 5 cycles -> fetch_req=1 for 5 cycles, pc held, then ir_load pulses for one cycle.
REQ-038 EXEC with branch_taken=1 and branch_target=0x103 -> pc=0x100 on the next cycle.
REQ-039 stall=1 for 4 cycles in EXEC with branch_taken=1 -> no PC change while stalled; a redirect occurs only when stall drops with branch_taken still 1.
REQ-040 pc=0xFFFFFFFC with sequential commit -> pc=0x00000000; then halt=1 in EXEC -> halted=1 and pc frozen at 0x4 after the next commit.
REQ-041 rst pulsed asynchronously mid-DECODE -> pc=RESET_PC and state_o=00 before the next edge; with PC_SEQUENCER_STALL_CNT_EN defined, stall_cnt reads 0.
